// File: rtl/xadc_multi_uart_streamer.sv
// Sweeps NUM_CH consecutive XADC aux channels over DRP on a fixed tick and
// ships each completed sweep as one framed 8N1 UART packet; unsent sweeps are counted.
module xadc_multi_uart_streamer #(
    parameter int unsigned NUM_CH       = 4,
    parameter logic [6:0]  BASE_ADDR    = 7'h14,
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned SAMPLE_DIV   = 12000,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic        drp_den,
    output logic [6:0]  drp_daddr,
    input  logic [15:0] drp_do,
    input  logic        drp_drdy,
    output logic        uart_tx,
    output logic        frame_busy,
    output logic [7:0]  drop_count
);

    localparam int unsigned TMR_W  = $clog2(SAMPLE_DIV);
    localparam int unsigned CLK_W  = $clog2(CLKS_PER_BIT);
    localparam int unsigned CH_W   = 4;
    localparam int unsigned IDX_W  = 6;
    localparam int unsigned MAX_CH = 16;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SAMPLE_DIV - 1);
    localparam logic [CLK_W-1:0] CLK_LAST = CLK_W'(CLKS_PER_BIT - 1);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2 * NUM_CH);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} sweep_state_t;

    sweep_state_t     r_state;
    sweep_state_t     w_state_nxt;
    logic [TMR_W-1:0] r_timer;
    logic             w_tick;
    logic [CH_W-1:0]  r_ch;
    logic [CH_W-1:0]  w_ch_nxt;
    logic [7:0]       r_wait_cnt;
    logic             w_capture;
    logic [11:0]      w_sample;
    logic             w_den_nxt;
    logic             w_load_frame;
    logic             w_sweep_drop;
    logic             w_tick_drop;
    logic [11:0]      r_buf    [MAX_CH];
    logic [11:0]      r_shadow [MAX_CH];
    logic             r_den;
    logic [6:0]       r_daddr;
    logic             r_busy;
    logic             r_tx;
    logic [CLK_W-1:0] r_clk_cnt;
    logic [3:0]       r_bit_cnt;
    logic [IDX_W-1:0] r_byte_idx;
    logic [CH_W-1:0]  w_tx_ch;
    logic [11:0]      w_tx_sample;
    logic [7:0]       w_tx_byte;
    logic [7:0]       r_drop;
    logic [8:0]       w_drop_sum;
    logic             w_unused;

    assign w_unused = ^drp_do[3:0];

    // Sweep tick timer; idles at zero while disabled
    assign w_tick = enable && (r_timer == TMR_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer <= '0;
        end else if (!enable || w_tick) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + TMR_W'(1);
        end
    end

    // A channel completes on drdy or after 256 cycles of silence (sample forced to FFF)
    assign w_capture = (r_state == S_WAIT) && (drp_drdy || (r_wait_cnt == 8'hFF));
    assign w_sample  = drp_drdy ? drp_do[15:4] : 12'hFFF;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_tick) w_state_nxt = S_REQ;
            S_REQ:   w_state_nxt = S_WAIT;
            S_WAIT:  if (w_capture) w_state_nxt = (r_ch == LAST_CH) ? S_DONE : S_REQ;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_den_nxt    = 1'b0;
        w_ch_nxt     = r_ch;
        w_load_frame = 1'b0;
        w_sweep_drop = 1'b0;
        w_tick_drop  = 1'b0;
        if (w_state_nxt == S_REQ) w_den_nxt = 1'b1;
        if ((r_state == S_IDLE) && w_tick) begin
            w_ch_nxt = '0;
        end else if (w_capture && (r_ch != LAST_CH)) begin
            w_ch_nxt = r_ch + CH_W'(1);
        end
        if (r_state == S_DONE) begin
            if (r_busy) w_sweep_drop = 1'b1;
            else        w_load_frame = 1'b1;
        end
        if (w_tick && (r_state != S_IDLE)) w_tick_drop = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ch       <= '0;
            r_wait_cnt <= '0;
            r_den      <= 1'b0;
            r_daddr    <= BASE_ADDR;
            for (int i = 0; i < MAX_CH; i++) r_buf[i] <= '0;
        end else begin
            r_ch  <= w_ch_nxt;
            r_den <= w_den_nxt;
            if (w_den_nxt) r_daddr <= BASE_ADDR + 7'(w_ch_nxt);
            if (r_state == S_REQ)       r_wait_cnt <= '0;
            else if (r_state == S_WAIT) r_wait_cnt <= r_wait_cnt + 8'd1;
            if (w_capture) r_buf[r_ch] <= w_sample;
        end
    end

    // Byte 0 is sync; then per channel a {ch, s[11:8]} header byte and an s[7:0] byte
    assign w_tx_ch     = CH_W'((r_byte_idx - IDX_W'(1)) >> 1);
    assign w_tx_sample = r_shadow[w_tx_ch];

    always_comb begin
        w_tx_byte = SYNC_BYTE;
        if (r_byte_idx != '0) begin
            w_tx_byte = r_byte_idx[0] ? {w_tx_ch, w_tx_sample[11:8]} : w_tx_sample[7:0];
        end
    end

    // 8N1 shifter: bit 0 start, 1..8 data LSB first, 9 stop; bytes back-to-back
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy     <= 1'b0;
            r_tx       <= 1'b1;
            r_clk_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_byte_idx <= '0;
            for (int i = 0; i < MAX_CH; i++) r_shadow[i] <= '0;
        end else if (w_load_frame) begin
            r_shadow   <= r_buf;
            r_busy     <= 1'b1;
            r_tx       <= 1'b0;
            r_clk_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_byte_idx <= '0;
        end else if (r_busy) begin
            if (r_clk_cnt == CLK_LAST) begin
                r_clk_cnt <= '0;
                if (r_bit_cnt == 4'd9) begin
                    r_bit_cnt <= '0;
                    if (r_byte_idx == LAST_IDX) begin
                        r_busy <= 1'b0;
                        r_tx   <= 1'b1;
                    end else begin
                        r_byte_idx <= r_byte_idx + IDX_W'(1);
                        r_tx       <= 1'b0;
                    end
                end else begin
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                    r_tx      <= (r_bit_cnt == 4'd8) ? 1'b1 : w_tx_byte[r_bit_cnt[2:0]];
                end
            end else begin
                r_clk_cnt <= r_clk_cnt + CLK_W'(1);
            end
        end
    end

    // Sweep drop and tick drop can coincide, so the counter may step by two
    assign w_drop_sum = 9'(r_drop) + 9'(w_sweep_drop) + 9'(w_tick_drop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop <= '0;
        end else begin
            r_drop <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
        end
    end

    assign drp_den    = r_den;
    assign drp_daddr  = r_daddr;
    assign uart_tx    = r_tx;
    assign frame_busy = r_busy;
    assign drop_count = r_drop;

endmodule

// File: tb/tb_xadc_multi_uart_streamer.sv
// Directed bench: frame content/timing, DRP timeout, reset mid-frame, enable gating,
// overflow drop accounting and drop counter saturation.
module tb_xadc_multi_uart_streamer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Instance A: 2 channels, slow tick, 3-cycle DRP latency
    logic        enable_a = 1'b0;
    logic        den_a, drdy_a, tx_a, busy_a;
    logic [6:0]  daddr_a;
    logic [15:0] do_a;
    logic [7:0]  drop_a;
    logic [2:0]  den_sr_a = 3'b000;
    logic [6:0]  addr_q_a = 7'h00;
    logic        mask_ch1 = 1'b0;
    logic        spur_a = 1'b0;

    always @(posedge clk) begin
        den_sr_a <= {den_sr_a[1:0], den_a};
        if (den_a) addr_q_a <= daddr_a;
    end
    assign drdy_a = (den_sr_a[2] && !(mask_ch1 && (addr_q_a == 7'h15))) || spur_a;
    assign do_a   = spur_a ? 16'hFFFF : ((addr_q_a == 7'h14) ? 16'h1230 : 16'hABC0);

    xadc_multi_uart_streamer #(
        .NUM_CH(2), .BASE_ADDR(7'h14), .CLKS_PER_BIT(4), .SAMPLE_DIV(400), .SYNC_BYTE(8'hA5)
    ) u_a (
        .clk(clk), .rst(rst), .enable(enable_a),
        .drp_den(den_a), .drp_daddr(daddr_a), .drp_do(do_a), .drp_drdy(drdy_a),
        .uart_tx(tx_a), .frame_busy(busy_a), .drop_count(drop_a)
    );

    // Instance B: overflow, tick every 100 cycles, 1-cycle DRP latency
    logic        enable_b = 1'b0;
    logic        den_b, tx_b, busy_b;
    logic        drdy_b = 1'b0;
    logic [6:0]  daddr_b;
    logic [7:0]  drop_b;
    always @(posedge clk) drdy_b <= den_b;

    xadc_multi_uart_streamer #(
        .NUM_CH(2), .BASE_ADDR(7'h14), .CLKS_PER_BIT(4), .SAMPLE_DIV(100), .SYNC_BYTE(8'hA5)
    ) u_b (
        .clk(clk), .rst(rst), .enable(enable_b),
        .drp_den(den_b), .drp_daddr(daddr_b), .drp_do(16'h1230), .drp_drdy(drdy_b),
        .uart_tx(tx_b), .frame_busy(busy_b), .drop_count(drop_b)
    );

    // Instance C: saturation, tick every 2 cycles, long 16-channel frames
    logic        enable_c = 1'b0;
    logic        den_c, tx_c, busy_c;
    logic        drdy_c = 1'b0;
    logic [6:0]  daddr_c;
    logic [7:0]  drop_c;
    always @(posedge clk) drdy_c <= den_c;

    xadc_multi_uart_streamer #(
        .NUM_CH(16), .BASE_ADDR(7'h14), .CLKS_PER_BIT(4), .SAMPLE_DIV(2), .SYNC_BYTE(8'hA5)
    ) u_c (
        .clk(clk), .rst(rst), .enable(enable_c),
        .drp_den(den_c), .drp_daddr(daddr_c), .drp_do(16'h0000), .drp_drdy(drdy_c),
        .uart_tx(tx_c), .frame_busy(busy_c), .drop_count(drop_c)
    );

    // A-side observers: DRP strobes, address hold, frame activity
    int         den_cnt_a = 0;
    int         busy_cnt_a = 0;
    int         hold_err = 0;
    logic [6:0] addr_log [0:3];
    logic [6:0] last_addr = 7'h00;
    bit         pend = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            pend = 1'b0;
        end else if (den_a) begin
            if (den_cnt_a < 4) addr_log[den_cnt_a] = daddr_a;
            den_cnt_a++;
            last_addr = daddr_a;
            pend = 1'b1;
        end else if (pend) begin
            if (daddr_a !== last_addr) hold_err++;
            if (drdy_a) pend = 1'b0;
        end
        if (busy_a) busy_cnt_a++;
    end

    // B-side frame monitor: sync byte and exact frame length
    bit         mon_b_en = 1'b0;
    int         b_cyc = 0;
    int         b_frames = 0;
    logic       b_prev = 1'b0;
    logic [7:0] b_byte0 = 8'h00;

    always @(negedge clk) begin
        if (mon_b_en) begin
            if (busy_b) begin
                b_cyc = b_prev ? b_cyc + 1 : 0;
                if ((b_cyc % 4 == 2) && (b_cyc / 4 >= 1) && (b_cyc / 4 <= 8))
                    b_byte0[b_cyc / 4 - 1] = tx_b;
                if (b_cyc == 38) begin
                    chk("ovf_sync", 32'(b_byte0), 32'h0A5);
                    b_frames++;
                end
            end else if (b_prev) begin
                chk("ovf_frame_len", 32'(b_cyc + 1), 32'd200);
            end
        end
        b_prev = busy_b;
    end

    // C-side: drop counter must never decrease
    int         sat_viol = 0;
    logic [7:0] prev_c = 8'h00;
    always @(negedge clk) begin
        if (!rst && (drop_c < prev_c)) sat_viol++;
        prev_c = drop_c;
    end

    // UART receiver for A, sampling mid-bit from the first busy cycle
    logic [7:0] rx_bytes [0:15];
    int         rx_len;
    int         rx_ferr;

    task automatic rx_frame(input int bound);
        int wt, c, b, i, p;
        wt = 0;
        while ((busy_a !== 1'b1) && (wt < bound)) begin
            @(negedge clk);
            wt++;
        end
        rx_len  = 0;
        rx_ferr = 0;
        for (int k = 0; k < 16; k++) rx_bytes[k] = 8'h00;
        if (busy_a !== 1'b1) begin
            chk("frame_start_timeout", 32'd0, 32'd1);
            return;
        end
        c = 0;
        while ((busy_a === 1'b1) && (c < 2000)) begin
            rx_len++;
            if (c % 4 == 2) begin
                b = c / 4;
                i = b / 10;
                p = b % 10;
                if (i < 16) begin
                    if (p == 0) begin
                        if (tx_a !== 1'b0) rx_ferr++;
                    end else if (p == 9) begin
                        if (tx_a !== 1'b1) rx_ferr++;
                    end else begin
                        rx_bytes[i][p-1] = tx_a;
                    end
                end
            end
            @(negedge clk);
            c++;
        end
    endtask

    task automatic expect_frame(input string tag, input logic [7:0] b3, input logic [7:0] b4);
        chk({tag, "_b0"}, 32'(rx_bytes[0]), 32'h0A5);
        chk({tag, "_b1"}, 32'(rx_bytes[1]), 32'h001);
        chk({tag, "_b2"}, 32'(rx_bytes[2]), 32'h023);
        chk({tag, "_b3"}, 32'(rx_bytes[3]), 32'(b3));
        chk({tag, "_b4"}, 32'(rx_bytes[4]), 32'(b4));
        chk({tag, "_busy_len"}, 32'(rx_len), 32'd200);
        chk({tag, "_framing"}, 32'(rx_ferr), 32'd0);
    endtask

    // One enable window of exactly n cycles from a cleared timer
    task automatic pulse_enable_a(input int n);
        enable_a = 1'b1;
        repeat (n) @(negedge clk);
        enable_a = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int den_base, busy_base, wt;

        repeat (5) @(negedge clk);
        chk("rst_uart_tx", 32'(tx_a), 32'd1);
        chk("rst_drp_den", 32'(den_a), 32'd0);
        chk("rst_drp_daddr", 32'(daddr_a), 32'h14);
        chk("rst_frame_busy", 32'(busy_a), 32'd0);
        chk("rst_drop_count", 32'(drop_a), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic frame
        pulse_enable_a(400);
        rx_frame(1000);
        expect_frame("basic", 8'h1A, 8'hBC);
        chk("basic_den_count", 32'(den_cnt_a), 32'd2);
        chk("basic_addr0", 32'(addr_log[0]), 32'h14);
        chk("basic_addr1", 32'(addr_log[1]), 32'h15);
        chk("basic_addr_hold", 32'(hold_err), 32'd0);

        // DRP timeout on ch1, then a normal sweep
        mask_ch1 = 1'b1;
        pulse_enable_a(400);
        rx_frame(1500);
        expect_frame("tmo", 8'h1F, 8'hFF);
        mask_ch1 = 1'b0;
        pulse_enable_a(400);
        rx_frame(1000);
        expect_frame("after_tmo", 8'h1A, 8'hBC);
        chk("after_tmo_drops", 32'(drop_a), 32'd0);

        // Reset during data bits of byte 2
        pulse_enable_a(400);
        wt = 0;
        while ((busy_a !== 1'b1) && (wt < 100)) begin
            @(negedge clk);
            wt++;
        end
        chk("rstmid_started", 32'(busy_a), 32'd1);
        repeat (90) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstmid_uart_tx", 32'(tx_a), 32'd1);
        chk("rstmid_frame_busy", 32'(busy_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pulse_enable_a(400);
        rx_frame(1000);
        expect_frame("post_rst", 8'h1A, 8'hBC);

        // Enable gating with spurious drdy while idle
        den_base  = den_cnt_a;
        busy_base = busy_cnt_a;
        repeat (20) begin
            repeat (99) @(negedge clk);
            spur_a = 1'b1;
            @(negedge clk);
            spur_a = 1'b0;
        end
        chk("gate_no_den", 32'(den_cnt_a - den_base), 32'd0);
        chk("gate_no_frame", 32'(busy_cnt_a - busy_base), 32'd0);
        chk("gate_drops", 32'(drop_a), 32'd0);
        chk("gate_buf0", 32'(u_a.r_buf[0]), 32'h123);
        chk("gate_buf1", 32'(u_a.r_buf[1]), 32'hABC);
        pulse_enable_a(399);
        repeat (5) @(negedge clk);
        pulse_enable_a(399);
        repeat (20) @(negedge clk);
        chk("gate_timer_cleared", 32'(den_cnt_a - den_base), 32'd0);

        // Overflow: 10 ticks, frames at ticks 1,4,7,10, the rest dropped
        mon_b_en = 1'b1;
        enable_b = 1'b1;
        repeat (1000) @(negedge clk);
        enable_b = 1'b0;
        repeat (600) @(negedge clk);
        mon_b_en = 1'b0;
        chk("ovf_frames", 32'(b_frames), 32'd4);
        chk("ovf_drop_count", 32'(drop_b), 32'd6);
        chk("ovf_drops_nonzero", 32'(drop_b > 8'd0), 32'd1);
        chk("ovf_ticks_minus_frames", 32'(drop_b), 32'(10 - b_frames));

        // Saturation
        enable_c = 1'b1;
        repeat (3000) @(negedge clk);
        chk("sat_reached", 32'(drop_c), 32'd255);
        repeat (500) @(negedge clk);
        chk("sat_held", 32'(drop_c), 32'd255);
        enable_c = 1'b0;
        chk("sat_monotonic", 32'(sat_viol), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
